// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: streaming 2D convolution with a signed KxK kernel.
// A kernel is loaded row-major (or the previous one is reused), then an
// IMG_HEIGHT x IMG_WIDTH frame streams in raster order. Every unpadded window
// result is emitted, scaled by >>> SHIFT and clamped to signed PIX_WIDTH.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, reuse_kernel        frame start (IDLE only); reuse skips kernel load
//   busy, done                 not-idle flag, one-cycle frame-complete pulse
//   k_valid, k_data, k_ready   kernel coefficient stream
//   in_valid, in_data, in_ready  pixel stream
//   out_valid, out_data, out_last, out_ready  result stream
module conv2d_stream_engine #(
  parameter int unsigned PIX_WIDTH  = 8,
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32,
  parameter int unsigned K          = 4,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned SHIFT      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 reuse_kernel,
  output logic                 busy,
  output logic                 done,
  input  logic                 k_valid,
  input  logic [PIX_WIDTH-1:0] k_data,
  output logic                 k_ready,
  input  logic                 in_valid,
  input  logic [PIX_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [PIX_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int unsigned ColW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned NumCoef = K * K;
  localparam int unsigned KIdxW   = $clog2(NumCoef);
  localparam int unsigned ProdW   = 2 * PIX_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] PixMax = ACC_WIDTH'((1 << (PIX_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] PixMin = ~PixMax;

  typedef enum logic [2:0] {
    StIdle,
    StLoadKernel,
    StStream,
    StDrain,
    StFinish
  } state_e;

  state_e                      state_q;
  logic [ColW-1:0]             col_q;
  logic [RowW-1:0]             row_q;
  logic [KIdxW-1:0]            kidx_q;
  logic signed [PIX_WIDTH-1:0] coef_q [NumCoef];
  logic signed [PIX_WIDTH-1:0] win_q  [K][K];
  logic signed [PIX_WIDTH-1:0] win_d  [K][K];
  logic [PIX_WIDTH-1:0]        lb_q   [K-1][IMG_WIDTH];
  logic                        out_valid_q;
  logic                        out_last_q;
  logic [PIX_WIDTH-1:0]        out_data_q;

  logic                        k_fire;
  logic                        px_fire;
  logic                        last_col;
  logic                        last_row;
  logic                        emit;
  logic signed [ProdW-1:0]     prod;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [PIX_WIDTH-1:0]        result;

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinish);
  assign k_ready   = (state_q == StLoadKernel);
  // A pending result blocks intake so nothing shifts while the sink stalls.
  assign in_ready  = (state_q == StStream) && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  assign k_fire   = k_valid && k_ready;
  assign px_fire  = in_valid && in_ready;
  assign last_col = (col_q == ColW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RowW'(IMG_HEIGHT - 1));
  // Row gating keeps stale line-buffer rows from a previous frame out of results.
  assign emit     = px_fire && (row_q >= RowW'(K - 1)) && (col_q >= ColW'(K - 1));

  // Window as seen with the accepted pixel: older columns shift left, the
  // newest column comes from the line-buffer taps plus the incoming pixel.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_d[r][K-1] = lb_q[K-2-r][col_q];
    end
    win_d[K-1][K-1] = in_data;
  end

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        prod = win_d[r][c] * coef_q[r*K+c];
        acc  = acc + $signed({{(ACC_WIDTH - ProdW){prod[ProdW-1]}}, prod});
      end
    end
    shifted = acc >>> SHIFT;
    if (shifted > PixMax) begin
      result = PixMax[PIX_WIDTH-1:0];
    end else if (shifted < PixMin) begin
      result = PixMin[PIX_WIDTH-1:0];
    end else begin
      result = shifted[PIX_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      kidx_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NumCoef; i++) begin
        coef_q[i] <= '0;
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= reuse_kernel ? StStream : StLoadKernel;
            kidx_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        StLoadKernel: begin
          if (k_fire) begin
            coef_q[kidx_q] <= k_data;
            if (kidx_q == KIdxW'(NumCoef - 1)) begin
              kidx_q  <= '0;
              state_q <= StStream;
            end else begin
              kidx_q <= kidx_q + 1'b1;
            end
          end
        end
        StStream: begin
          if (px_fire) begin
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                row_q   <= '0;
                state_q <= StDrain;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (!out_valid_q || out_ready) begin
            state_q <= StFinish;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase

      if (px_fire) begin
        win_q <= win_d;
      end

      if (emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result;
        out_last_q  <= last_row && last_col;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  // Line buffers: lb_q[j] holds the row j+1 above the current one.
  always_ff @(posedge clk) begin
    if (px_fire) begin
      lb_q[0][col_q] <= in_data;
      for (int j = 1; j < K - 1; j++) begin
        lb_q[j][col_q] <= lb_q[j-1][col_q];
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Bench for conv2d_stream_engine: an 8x8/K=4 instance checked against an
// arithmetic reference model, plus a 2x2/K=2/SHIFT=2 instance for rounding.
module tb_conv2d_stream_engine;

  localparam int P = 8;
  localparam int W = 8;
  localparam int H = 8;
  localparam int K = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, reuse_kernel, k_valid, in_valid, out_ready;
  logic [P-1:0] k_data, in_data, out_data;
  logic         busy, done, k_ready, in_ready, out_valid, out_last;

  logic         b_start, b_reuse, b_k_valid, b_in_valid, b_out_ready;
  logic [P-1:0] b_k_data, b_in_data, b_out_data;
  logic         b_busy, b_done, b_k_ready, b_in_ready, b_out_valid, b_out_last;

  conv2d_stream_engine #(
    .PIX_WIDTH(P), .IMG_WIDTH(W), .IMG_HEIGHT(H), .K(K), .ACC_WIDTH(20), .SHIFT(0)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .reuse_kernel(reuse_kernel),
    .busy(busy), .done(done), .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  conv2d_stream_engine #(
    .PIX_WIDTH(P), .IMG_WIDTH(2), .IMG_HEIGHT(2), .K(2), .ACC_WIDTH(20), .SHIFT(2)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .reuse_kernel(b_reuse),
    .busy(b_busy), .done(b_done), .k_valid(b_k_valid), .k_data(b_k_data),
    .k_ready(b_k_ready), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_last(b_out_last), .out_ready(b_out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: direct convolution over the stored frame.
  typedef struct {
    logic [P-1:0] data;
    logic         last;
  } exp_t;

  int   img [H][W];
  int   ker [K][K];
  exp_t exp_q [$];

  function automatic void build_expected();
    exp_q.delete();
    for (int r = 0; r <= H - K; r++) begin
      for (int c = 0; c <= W - K; c++) begin
        int s;
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += img[r+i][c+j] * ker[i][j];
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        exp_q.push_back('{data: P'(s), last: (r == H - K) && (c == W - K)});
      end
    end
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sink: always ready, or ready one cycle in three.
  int rdy_mode = 0;
  int ph = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      out_ready = (rdy_mode == 0) ? 1'b1 : ((ph % 3) == 0);
    end
  end

  // Result monitor and stall-protocol checks, sampled mid-cycle.
  logic         mon_en = 1'b0;
  logic         no_k_chk = 1'b0;
  logic         stalled_prev = 1'b0;
  logic [P-1:0] prev_data;
  exp_t         e;
  always @(negedge clk) begin
    if (!mon_en || reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, prev_data);
      end
      if (out_valid && !out_ready) check_eq("stall_in_ready", in_ready, 0);
      if (no_k_chk) check_eq("reuse_k_ready", k_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_data", out_data, e.data);
          check_eq("out_last", out_last, e.last);
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev_data    = out_data;
    end
  end

  // Runs one frame on the main instance. abort_at >= 0 pulses reset right
  // after that pixel index is accepted. lat = cycles from last accept to done.
  task automatic run_frame(input bit reuse, input int in_prob, input int abort_at,
                           output int lat);
    int  last_cyc;
    bit  ok;
    lat = -1;
    last_cyc = 0;
    start = 1'b1;
    reuse_kernel = reuse;
    @(posedge clk);
    #1;
    start = 1'b0;
    reuse_kernel = 1'b0;
    if (reuse) begin
      @(negedge clk);
      check_eq("reuse_k_ready_first", k_ready, 0);
      check_eq("reuse_stream_entry", in_ready, 1);
      no_k_chk = 1'b1;
      @(posedge clk);
      #1;
    end else begin
      for (int idx = 0; idx < K * K; idx++) begin
        k_valid = 1'b1;
        k_data  = P'(ker[idx/K][idx%K]);
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
          @(negedge clk);
          ok = k_ready;
          @(posedge clk);
          #1;
        end
        if (!ok) check_eq("k_ready_timeout", 0, 1);
      end
      k_valid = 1'b0;
    end
    for (int p = 0; p < H * W; p++) begin
      ok = 1'b0;
      in_data = P'(img[p/W][p%W]);
      for (int t = 0; t < 500 && !ok; t++) begin
        in_valid = ($urandom_range(99) < in_prob);
        @(negedge clk);
        ok = in_valid && in_ready;
        last_cyc = cyc;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
        check_eq("in_ready_timeout", 0, 1);
        break;
      end
      if (p == abort_at) begin
        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_k_ready", k_ready, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_done", done, 0);
        reset = 1'b0;
        return;
      end
    end
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      ok = done;
    end
    if (!ok) begin
      check_eq("done_timeout", 0, 1);
    end else begin
      lat = cyc - last_cyc;
      @(negedge clk);
      check_eq("done_pulse_width", done, 0);
      check_eq("idle_after_done", busy, 0);
    end
    no_k_chk = 1'b0;
    check_eq("results_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_b(input int kv, input int p0, input int p1, input int p2, input int p3,
                       input logic [P-1:0] expv);
    bit ok;
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_k_valid = 1'b1;
      b_k_data  = P'(kv);
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk);
        ok = b_k_ready;
        @(posedge clk);
        #1;
      end
      if (!ok) check_eq("b_k_ready_timeout", 0, 1);
    end
    b_k_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = P'((i == 0) ? p0 : (i == 1) ? p1 : (i == 2) ? p2 : p3);
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk);
        ok = b_in_ready;
        @(posedge clk);
        #1;
      end
      if (!ok) check_eq("b_in_ready_timeout", 0, 1);
    end
    b_in_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = b_out_valid;
    end
    check_eq("b_out_valid", ok, 1);
    check_eq("b_out_data", b_out_data, expv);
    check_eq("b_out_last", b_out_last, 1);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = b_done;
    end
    check_eq("b_done", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_kernel(input int mode);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        case (mode)
          0:       ker[i][j] = (i == 0 && j == 0) ? 1 : 0;
          1:       ker[i][j] = 1;
          2:       ker[i][j] = -1;
          default: ker[i][j] = $signed($urandom_range(4)) - 2;
        endcase
  endtask

  task automatic set_image(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = r * W + c;
          1:       img[r][c] = 127;
          default: img[r][c] = $signed($urandom_range(16)) - 8;
        endcase
  endtask

  int lat;

  initial begin
    reset = 1'b1;
    start = 1'b0; reuse_kernel = 1'b0; k_valid = 1'b0; k_data = '0;
    in_valid = 1'b0; in_data = '0;
    b_start = 1'b0; b_reuse = 1'b0; b_k_valid = 1'b0; b_k_data = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_out_last", out_last, 0);
    check_eq("reset_out_data", out_data, 0);
    check_eq("reset_k_ready", k_ready, 0);
    check_eq("reset_in_ready", in_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Identity-corner kernel over a ramp image.
    set_kernel(0); set_image(0); build_expected();
    mon_en = 1'b1;
    run_frame(1'b0, 100, -1, lat);
    check_eq("done_latency", lat, 2);

    // Saturation both ways.
    set_kernel(1); set_image(1); build_expected();
    run_frame(1'b0, 100, -1, lat);
    set_kernel(2); build_expected();
    run_frame(1'b0, 100, -1, lat);

    // Backpressure with bursty input.
    set_kernel(0); set_image(0); build_expected();
    rdy_mode = 1;
    run_frame(1'b0, 60, -1, lat);
    rdy_mode = 0;

    // Kernel reuse must reproduce the same frame.
    build_expected();
    run_frame(1'b1, 100, -1, lat);

    // Random signed kernel and pixels under backpressure.
    set_kernel(3); set_image(2); build_expected();
    rdy_mode = 1;
    run_frame(1'b0, 70, -1, lat);
    rdy_mode = 0;

    // Reset while accepting row 3, then a fresh load and full frame.
    set_kernel(0); set_image(0); build_expected();
    run_frame(1'b0, 100, 3 * W + 2, lat);
    exp_q.delete();
    @(posedge clk);
    #1;
    set_kernel(3); set_image(2); build_expected();
    mon_en = 1'b1;
    run_frame(1'b0, 100, -1, lat);
    mon_en = 1'b0;

    // Floor-shift rounding on the SHIFT=2, K=2 instance.
    run_b(-1, 1, 2, 2, 2, 8'hFE);
    run_b(1, 1, 2, 2, 2, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
